// File: rtl/timer_counter_if.sv
// rtl/timer_counter_if.sv - CPU data-port bus bundle between the bridge and a timer_counter
interface timer_counter_if;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        err;

  modport master (output addr, output we, output byteen, output wdata,
                  input rdata, input err);
  modport slave  (input addr, input we, input byteen, input wdata,
                  output rdata, output err);
endinterface

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped countdown timer with CP0 interrupt; TC_AUTORELOAD_EN enables MODE 01 auto-reload
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus,
  output logic            irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic hit, wr, wr_ctrl, wr_preset, wr_count;
  logic auto_reload;
  logic unused_addr_bits;

  // Word offset 3 inside the window is a hole: it neither decodes nor errors.
  assign hit       = (bus.addr[31:4] == BASE_ADDR[31:4]) && (bus.addr[3:2] != 2'b11);
  assign wr        = hit & bus.we;
  assign wr_ctrl   = wr && (bus.addr[3:2] == 2'b00);
  assign wr_preset = wr && (bus.addr[3:2] == 2'b01);
  assign wr_count  = wr && (bus.addr[3:2] == 2'b10);
  assign unused_addr_bits = ^bus.addr[1:0];

`ifdef TC_AUTORELOAD_EN
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
`else
  assign auto_reload = 1'b0;
`endif

  assign bus.err = wr_count;
  assign irq     = irq_flag_q & ctrl_q[3];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Read mux: addressed register when decoded, zero otherwise.
  always_comb begin
    bus.rdata = '0;
    if (hit) begin
      case (bus.addr[3:2])
        2'b00:   bus.rdata = {28'd0, ctrl_q};
        2'b01:   bus.rdata = preset_q;
        2'b10:   bus.rdata = count_q;
        default: bus.rdata = '0;
      endcase
    end
  end

  // Next-state: FSM updates first, then bus writes override CTRL and clear the flag.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      IDLE: begin
        if (ctrl_q[0]) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[0]) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = '0;
          irq_flag_d = 1'b1;
          state_d    = INT;
        end
      end
      INT: begin
        state_d = IDLE;
        if (auto_reload) irq_flag_d = 1'b0;
        else             ctrl_d[0]  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // CTRL only holds byte 0 bits; any CTRL write acknowledges the interrupt.
    if (wr_ctrl) begin
      if (bus.byteen[0]) ctrl_d = bus.wdata[3:0];
      irq_flag_d = 1'b0;
    end

    // PRESET is latched into COUNT only at LOAD, so a running count is unaffected.
    if (wr_preset) preset_d = merge_bytes(preset_q, bus.wdata, bus.byteen);
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - randomized self-checking bench for timer_counter against an age-based model (honours TC_AUTORELOAD_EN)
module tb_timer_counter;
  localparam logic [31:0] BASE = 32'h0000_7F00;
`ifdef TC_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic irq;

  timer_counter_if bus();

  timer_counter #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a run is described by its age in edges since it left idle.
  // age 1 = reload pending, age 2 = COUNT loaded, expiry at age 2+max(N,1),
  // one more edge afterwards ends the run.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count, m_n;
  bit          m_flag, m_run;
  longint      m_age;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    return (a[31:4] == BASE[31:4]) && (a[3:2] != 2'b11);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_hit(a)) return 32'd0;
    case (a[3:2])
      2'b00:   return {28'd0, m_ctrl};
      2'b01:   return m_preset;
      2'b10:   return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_preset = '0; m_count = '0; m_n = '0;
    m_flag = 1'b0; m_run = 1'b0; m_age = 0;
  endtask

  task automatic model_edge(input logic [31:0] a, input bit w, input logic [3:0] be,
                            input logic [31:0] wd);
    logic [3:0]  c;
    logic [31:0] p, cnt;
    bit          f, run;
    longint      age, lim, nxt;
    c = m_ctrl; p = m_preset; cnt = m_count; f = m_flag; run = m_run; age = m_age;
    if (!m_run) begin
      if (m_ctrl[0]) begin run = 1'b1; age = 1; end
    end else if (m_age == 1) begin
      m_n = m_preset;
      cnt = m_preset;
      age = 2;
    end else begin
      lim = 2 + ((m_n == 0) ? 1 : longint'(m_n));
      if (m_age < lim) begin
        if (!m_ctrl[0]) begin
          run = 1'b0;
        end else begin
          nxt = m_age + 1;
          cnt = (nxt - 2 >= longint'(m_n)) ? 32'd0 : 32'(longint'(m_n) - (nxt - 2));
          if (nxt == lim) f = 1'b1;
          age = nxt;
        end
      end else begin
        run = 1'b0;
        if (AUTO && m_ctrl[2:1] == 2'b01) f = 1'b0;
        else c[0] = 1'b0;
      end
    end
    if (m_hit(a) && w) begin
      if (a[3:2] == 2'b00) begin
        if (be[0]) c = wd[3:0];
        f = 1'b0;
      end else if (a[3:2] == 2'b01) begin
        for (int b = 0; b < 4; b++) if (be[b]) p[8*b +: 8] = wd[8*b +: 8];
      end
    end
    m_ctrl = c; m_preset = p; m_count = cnt; m_flag = f; m_run = run; m_age = age;
  endtask

  // One bus cycle: drive, check combinational outputs, clock, check irq.
  task automatic bus_cycle(input logic [31:0] a, input bit w, input logic [3:0] be,
                           input logic [31:0] wd);
    bus.addr = a; bus.we = w; bus.byteen = be; bus.wdata = wd;
    #1;
    last_rdata = bus.rdata;
    last_err   = bus.err;
    check("rdata", bus.rdata, m_read(a));
    check("err", 32'(bus.err), 32'(m_hit(a) && w && (a[3:2] == 2'b10)));
    @(posedge clk);
    model_edge(a, w, be, wd);
    #1;
    check("irq", 32'(irq), 32'(m_flag & m_ctrl[3]));
  endtask

  task automatic rd(input logic [31:0] a);
    bus_cycle(a, 1'b0, 4'h0, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_cycle(a, 1'b1, 4'hF, d);
  endtask

  initial begin
    bus.addr = '0; bus.we = 1'b0; bus.byteen = '0; bus.wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_irq", 32'(irq), 32'd0);
    reset = 1'b1;

    // reset values
    rd(BASE);     check("rst_ctrl", last_rdata, 32'd0);
    rd(BASE + 4); check("rst_preset", last_rdata, 32'd0);
    rd(BASE + 8); check("rst_count", last_rdata, 32'd0);

    // byte enables
    wr(BASE + 4, 32'h1122_3344);
    bus_cycle(BASE + 4, 1'b1, 4'b0101, 32'hAABB_CCDD);
    rd(BASE + 4); check("be_merge", last_rdata, 32'h11BB_33DD);

    // illegal write to COUNT and the hole at offset 0xC
    wr(BASE + 8, 32'hDEAD_BEEF); check("cnt_wr_err", 32'(last_err), 32'd1);
    rd(BASE + 8);  check("cnt_unchanged", last_rdata, 32'd0);
    wr(BASE + 12, 32'h5);        check("hole_err", 32'(last_err), 32'd0);
    rd(BASE + 12); check("hole_rdata", last_rdata, 32'd0);

    // one-shot, PRESET=5, CTRL=0x9 written at edge k
    wr(BASE + 4, 32'd5);
    wr(BASE, 32'h9);
    for (int i = 1; i <= 9; i++) begin
      rd((i == 9) ? BASE : BASE + 8);
      if (i == 3) check("os_cnt_k2", last_rdata, 32'd5);
      if (i == 4) check("os_cnt_k3", last_rdata, 32'd4);
      if (i == 6) check("os_irq_k6", 32'(irq), 32'd0);
      if (i >= 7) check("os_irq_held", 32'(irq), 32'd1);
      if (i == 9) check("os_ctrl_k8", last_rdata, 32'h8);
    end
    wr(BASE, 32'h8); check("os_irq_clr", 32'(irq), 32'd0);

    // auto-reload (or held one-shot without the macro), PRESET=3, CTRL=0xB
    wr(BASE + 4, 32'd3);
    wr(BASE, 32'hB);
    for (int i = 1; i <= 18; i++) begin
      rd(BASE + 8);
      check("ar_irq", 32'(irq),
            AUTO ? 32'(i == 5 || i == 11 || i == 17) : 32'(i >= 5));
    end
    wr(BASE, 32'h0);
    repeat (3) rd(BASE);

    // PRESET=0: irq at k+3
    wr(BASE + 4, 32'd0);
    wr(BASE, 32'h9);
    for (int i = 1; i <= 3; i++) begin
      rd(BASE + 8);
      check("p0_irq", 32'(irq), 32'(i == 3));
    end
    wr(BASE, 32'h0);
    repeat (2) rd(BASE);

    // clearing EN mid-count holds COUNT at 7
    wr(BASE + 4, 32'd10);
    wr(BASE, 32'h1);
    repeat (4) rd(BASE + 8);
    wr(BASE, 32'h0);
    repeat (3) rd(BASE + 8);
    check("hold_cnt", last_rdata, 32'd7);

    // IM=0: flag sets internally but irq stays low
    wr(BASE + 4, 32'd2);
    wr(BASE, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      rd(BASE);
      check("im0_irq", 32'(irq), 32'd0);
    end

    // asynchronous reset with irq asserted
    wr(BASE + 4, 32'd1);
    wr(BASE, 32'h9);
    repeat (5) rd(BASE + 8);
    check("pre_rst_irq", 32'(irq), 32'd1);
    #2 reset = 1'b0;
    #1 check("async_rst_irq", 32'(irq), 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    rd(BASE);     check("rst2_ctrl", last_rdata, 32'd0);
    rd(BASE + 4); check("rst2_preset", last_rdata, 32'd0);
    rd(BASE + 8); check("rst2_count", last_rdata, 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, d;
      logic [3:0]  be;
      bit          w;
      case ($urandom_range(0, 6))
        0, 1:    a = BASE;
        2:       a = BASE + 4;
        3:       a = BASE + 8;
        4:       a = BASE + 12;
        5:       a = BASE + 16;
        default: a = $urandom;
      endcase
      w  = ($urandom_range(0, 7) == 0);
      be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      d  = $urandom;
      if (a == BASE) d[0] = ($urandom_range(0, 3) != 0);
      if (a == BASE + 4 && $urandom_range(0, 7) != 0) d = $urandom_range(0, 6);
      bus_cycle(a, w, be, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped countdown timer that sits directly downstream of the CPU core's data port, behind the system bridge. It decodes the core's data address, write enable, byte enables and write data to expose three registers, and it drives one interrupt line back into the core's CP0 hardware-interrupt inputs. Two instances (Timer0, Timer1) are built with different base addresses.

## Interface
- `BASE_ADDR`, default 32'h0000_7F00: word-aligned base address; the block occupies BASE_ADDR..BASE_ADDR+0xB.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: **asynchronous, active-low** reset; all state is cleared while it is low.
- `addr` input 32: data address from the core (`m_data_addr`).
- `we` input 1: bus write strobe from the bridge.
- `byteen` input 4: byte enables (`m_data_byteen`); bit i covers `wdata[8i+7:8i]`.
- `wdata` input 32: write data.
- `rdata` output 32: read data, combinational from `addr`.
- `err` output 1: illegal access for the CPU's AdES path; combinational.
- `irq` output 1: interrupt request to CP0.

## Operation
- **Address decode.** `hit` = (`addr[31:4]` == `BASE_ADDR[31:4]`) and (`addr[3:2]` != 2'b11).
  - Offset 0x0 is CTRL (r/w).
  - Offset 0x4 is PRESET (r/w).
  - Offset 0x8 is COUNT (read-only).
- **CTRL fields.** `[0]` EN, `[2:1]` MODE (00 one-shot, 01 auto-reload; 10/11 behave as 00), `[3]` IM (interrupt mask). Bits 31:4 read as 0 and ignore writes.
- **Writes.** A write happens when `hit & we`.
  - Each byte with its `byteen` bit set updates; bytes with a clear bit are unchanged.
  - A write to COUNT changes nothing and asserts `err`. `err` is 0 otherwise.
- **Reads.** `rdata` is the addressed register when `hit`, else 0.
- **State machine** (states IDLE, LOAD, CNT, INT):
  - IDLE: if EN then go to LOAD, else stay.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If !EN, go to IDLE and COUNT holds.
    - Else if COUNT > 1, COUNT <= COUNT-1.
    - Else COUNT <= 0, irq_flag <= 1, and go to INT.
  - INT, MODE 00: clear EN; go to IDLE; irq_flag is held.
  - INT, MODE 01: irq_flag <= 0; go to IDLE. EN is still set, so the timer reloads.
- **irq.** `irq` = irq_flag & IM.
- **irq_flag clearing.** irq_flag clears on any CTRL write, or on the INT exit in MODE 01.
- **Simultaneous events.**
  - A bus write to CTRL in the same cycle the FSM clears EN: the bus value wins.
  - The bus write to CTRL in the same cycle as the set: clear wins, so irq_flag ends 0.
  - PRESET writes during CNT do not affect the running COUNT; the new value is used at the next LOAD.
- **PRESET = 0.** LOAD loads 0; the next CNT cycle takes the else-branch and enters INT.
- **Arithmetic.** COUNT is 32-bit unsigned and never wraps below 0.

## Timing
- **Reset values.** CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0.
  - `irq`=0; `err`=0.
  - `rdata`=0 for every address.
- **Reset mid-count.** Returns to IDLE immediately and asynchronously; `irq` drops without waiting for a clock edge.
- **Start-up latency.** Take CTRL.EN written at edge k and PRESET=N≥1.
  - Edge k+1: state=LOAD.
  - Edge k+2: COUNT=N, state=CNT.
  - Edge k+2+N: COUNT=0, state=INT, irq_flag=1.
- **N=0.** irq_flag=1 at edge k+3.
- **MODE 00.** Edge k+3+N: state=IDLE, EN=0; `irq` stays high until a CTRL write.
- **MODE 01.**
  - Edge k+3+N: IDLE; `irq` is high for exactly one cycle.
  - Edge k+4+N: LOAD.
  - Edge k+5+N: COUNT=N.
  - Interrupt period is N+3 cycles.
- **Combinational outputs.** `rdata` and `err` have zero-cycle latency; register updates appear at the next rising edge.

## Configuration
- `TC_AUTORELOAD_EN` defined: MODE 01 behaves as auto-reload as described above.
- `TC_AUTORELOAD_EN` undefined:
  - MODE 01 behaves exactly as MODE 00 (one-shot, EN cleared, `irq` held).
  - The MODE field remains read/write.

## Test plan
- **Reset.** Hold `reset`=0 mid-count with irq_flag=1 → `irq`=0 immediately; after release, read 0x7F00/0x7F04/0x7F08 → 0, 0, 0.
- **One-shot.** PRESET=5, then CTRL=0x9 at edge k → COUNT=5 at k+2, 4 at k+3; `irq`=1 from k+7. CTRL reads 0x8 at k+8. Writing CTRL=0x8 → `irq`=0 next cycle.
- **Auto-reload** (macro defined). PRESET=3, CTRL=0xB → `irq` pulses one cycle at k+5, k+11, k+17. Without the macro → a single `irq` that is held.
- **Byte enables.** PRESET=0x11223344; write 0xAABBCCDD with byteen=4'b0101 → PRESET reads 0x11BB33DD.
- **Illegal write.** Write to 0x7F08 with we=1 → `err`=1 and COUNT unchanged. A read of 0x7F0C → `rdata`=0 and `err`=0.
- **Edge cases.**
  - PRESET=0 with EN set at k → `irq`=1 at k+3.
  - Clearing EN during CNT with COUNT=7 → COUNT holds 7 and state goes to IDLE.
  - IM=0 → irq_flag sets but `irq` stays 0.
